// File: rtl/response_checker_if.sv
// Bus bundle for response_checker: expected-table writes, run control,
// the DUT sample stream and the grading results.
// The first_fail_* signals are always present; they read as zero unless the
// checker is built with RESP_CHECK_FIRST_FAIL_EN.
interface response_checker_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CW-1:0]    mismatch_count;
    logic             first_fail_valid;
    logic [AW-1:0]    first_fail_idx;
    logic [WIDTH-1:0] first_fail_data;

    // Harness side: programs the table, starts runs, feeds samples.
    modport master (
        output wr_en, wr_addr, wr_data, start, sample_valid, sample,
        input  busy, done, pass, mismatch_count,
               first_fail_valid, first_fail_idx, first_fail_data
    );

    // Checker side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, sample_valid, sample,
        output busy, done, pass, mismatch_count,
               first_fail_valid, first_fail_idx, first_fail_data
    );
endinterface

// File: rtl/response_checker.sv
// response_checker: golden-response checker for a DUT output stream.
// A table of DEPTH expected samples is programmed while idle; a start pulse
// begins a run, every accepted sample is graded against the table entry at
// the current index, and after DEPTH samples the result (done/pass and the
// mismatch count) is held until the next start or reset.
// The expected table has no reset so a programmed golden vector survives rst.
// Optional feature macro: RESP_CHECK_FIRST_FAIL_EN captures the index and
// value of the first mismatching sample of each run.
module response_checker #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    response_checker_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] exp_table [DEPTH];
    logic [AW-1:0]    idx;
    logic [CW-1:0]    mismatch_count;

    logic             busy;
    logic             done;
    logic             pass;

    logic             wr_ok;
    logic             addr_in_range;
    logic             run_start;
    logic             accept;
    logic             last_sample;
    logic             mismatch;

    // Writes are locked out during a run so the run is graded against a
    // stable table; addresses beyond the table are dropped rather than wrapped.
    assign addr_in_range = (32'(bus.wr_addr) < 32'(DEPTH));
    assign wr_ok         = bus.wr_en && (state_q != RUN) && addr_in_range;

    // A start pulse only begins a run from IDLE or DONE; mid-run it is ignored.
    assign run_start     = bus.start && (state_q != RUN);

    // Samples are only meaningful while running; idx holds across valid gaps.
    assign accept        = bus.sample_valid && (state_q == RUN);
    assign last_sample   = (idx == AW'(DEPTH - 1));
    assign mismatch      = accept && (bus.sample != exp_table[idx]);

    // Expected-vector storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            exp_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs derived from the current state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (accept && last_sample) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                pass = (mismatch_count == '0);
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample index and mismatch counter; both restart at the beginning of
    // every run and the counter is wide enough to reach DEPTH without wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            mismatch_count <= '0;
        end else if (run_start) begin
            idx            <= '0;
            mismatch_count <= '0;
        end else if (accept) begin
            if (!last_sample) begin
                idx <= idx + AW'(1);
            end
            if (mismatch) begin
                mismatch_count <= mismatch_count + CW'(1);
            end
        end
    end

`ifdef RESP_CHECK_FIRST_FAIL_EN
    logic             ff_valid;
    logic [AW-1:0]    ff_idx;
    logic [WIDTH-1:0] ff_data;

    // Latch where the run first went wrong; later mismatches leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_valid <= 1'b0;
            ff_idx   <= '0;
            ff_data  <= '0;
        end else if (run_start) begin
            ff_valid <= 1'b0;
            ff_idx   <= '0;
            ff_data  <= '0;
        end else if (mismatch && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx   <= idx;
            ff_data  <= bus.sample;
        end
    end

    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_idx   = ff_idx;
    assign bus.first_fail_data  = ff_data;
`else
    assign bus.first_fail_valid = 1'b0;
    assign bus.first_fail_idx   = '0;
    assign bus.first_fail_data  = '0;
`endif

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.mismatch_count = mismatch_count;

endmodule
